// File: rtl/pr_pkg.sv
// result_printer shared types: FSM states, character codes, line length.
// PRINT_CRLF_EN selects a CR/LF line terminator instead of a single space.
package pr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } state_t;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

`ifdef PRINT_CRLF_EN
  localparam int NCHAR = 6;
  localparam logic [7:0] TERM0 = CH_CR;
`else
  localparam int NCHAR = 5;
  localparam logic [7:0] TERM0 = CH_SP;
`endif

  localparam logic [2:0] LAST_IDX = 3'(NCHAR - 1);

endpackage

// File: rtl/result_printer_if.sv
// Adder-result capture and UART transmit signals of result_printer.
// The printer is the slave; the adder/UART environment is the master.
interface result_printer_if;

  logic [7:0] L2_adder_data1;
  logic       L2_adder_rdy1;
  logic [7:0] L2_adder_data2;
  logic       L2_adder_rdy2;
  logic       bu_tx_busy;
  logic [7:0] Gl_tx_data;
  logic       Gl_tx_data_rdy;
  logic       pr_busy;
  logic       pr_drop;

  modport master (
    output L2_adder_data1,
    output L2_adder_rdy1,
    output L2_adder_data2,
    output L2_adder_rdy2,
    output bu_tx_busy,
    input  Gl_tx_data,
    input  Gl_tx_data_rdy,
    input  pr_busy,
    input  pr_drop
  );

  modport slave (
    input  L2_adder_data1,
    input  L2_adder_rdy1,
    input  L2_adder_data2,
    input  L2_adder_rdy2,
    input  bu_tx_busy,
    output Gl_tx_data,
    output Gl_tx_data_rdy,
    output pr_busy,
    output pr_drop
  );

endinterface

// File: rtl/hex2ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex2ascii (
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  always_comb begin
    if (nib_i < 4'd10) asc_o = 8'h30 + {4'h0, nib_i};
    else               asc_o = 8'h37 + {4'h0, nib_i};
  end

endmodule

// File: rtl/result_printer.sv
// Captures two adder result bytes and prints them as a hex line over UART.
// Line terminator is CR/LF when PRINT_CRLF_EN is defined, else a space.
module result_printer
  import pr_pkg::*;
(
  input logic        clk,
  input logic        Gl_rst_n,
  result_printer_if.slave bus
);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] prn_q, prn_d;
  logic [7:0]  cap1_q, cap2_q;
  logic        v1_q, v2_q;
  logic        drop_q;
  logic [7:0]  txd_q, txd_d;
  logic        txr_q, txr_d;

  logic        snap;
  logic [3:0]  nib;
  logic [7:0]  hex_ch;
  logic [7:0]  ch;

  assign snap = (state_q == IDLE) && v1_q && v2_q;

  always_comb begin
    unique case (idx_q)
      3'd0:    nib = prn_q[15:12];
      3'd1:    nib = prn_q[11:8];
      3'd2:    nib = prn_q[7:4];
      default: nib = prn_q[3:0];
    endcase
  end

  hex2ascii u_hex (
    .nib_i (nib),
    .asc_o (hex_ch)
  );

  always_comb begin
    ch = hex_ch;
    if (idx_q == 3'd4) ch = TERM0;
    if (idx_q == 3'd5) ch = CH_LF;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    prn_d   = prn_q;
    txd_d   = txd_q;
    txr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (snap) begin
          prn_d   = {cap1_q, cap2_q};
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!bus.bu_tx_busy) begin
          txd_d   = ch;
          txr_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A byte consumed by the snapshot in the same cycle is not a drop.
  always_ff @(posedge clk) begin
    if (!Gl_rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      prn_q   <= 16'h0000;
      cap1_q  <= 8'h00;
      cap2_q  <= 8'h00;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      drop_q  <= 1'b0;
      txd_q   <= 8'h00;
      txr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prn_q   <= prn_d;
      txd_q   <= txd_d;
      txr_q   <= txr_d;
      if (bus.L2_adder_rdy1) cap1_q <= bus.L2_adder_data1;
      if (bus.L2_adder_rdy2) cap2_q <= bus.L2_adder_data2;
      v1_q   <= bus.L2_adder_rdy1 | (v1_q & ~snap);
      v2_q   <= bus.L2_adder_rdy2 | (v2_q & ~snap);
      drop_q <= ~snap & ((bus.L2_adder_rdy1 & v1_q) |
                         (bus.L2_adder_rdy2 & v2_q));
    end
  end

  assign bus.Gl_tx_data     = txd_q;
  assign bus.Gl_tx_data_rdy = txr_q;
  assign bus.pr_busy        = (state_q != IDLE);
  assign bus.pr_drop        = drop_q;

endmodule

// File: tb/tb_result_printer.sv
// Scoreboard bench for result_printer: expected characters are queued
// when results are driven and popped on each transmit strobe.
module tb_result_printer;

`ifdef PRINT_CRLF_EN
  localparam int NC = 6;
`else
  localparam int NC = 5;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  result_printer_if bus ();

  result_printer dut (
    .clk      (clk),
    .Gl_rst_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int drop_cnt = 0;
  logic [7:0] exp_q[$];
  string hx = "0123456789ABCDEF";

  always @(posedge clk) begin
    cyc++;
    #2;
    if (bus.Gl_tx_data_rdy === 1'b1) strobe_cnt++;
    if (bus.pr_drop === 1'b1) drop_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  task automatic push_line(input logic [7:0] d1, input logic [7:0] d2);
    exp_q.push_back(hx[d1[7:4]]);
    exp_q.push_back(hx[d1[3:0]]);
    exp_q.push_back(hx[d2[7:4]]);
    exp_q.push_back(hx[d2[3:0]]);
`ifdef PRINT_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h20);
`endif
  endtask

  task automatic pulse(input bit a, input bit b,
                       input logic [7:0] d1, input logic [7:0] d2);
    bus.L2_adder_data1 = d1;
    bus.L2_adder_data2 = d2;
    bus.L2_adder_rdy1  = a;
    bus.L2_adder_rdy2  = b;
    @(negedge clk);
    bus.L2_adder_rdy1 = 1'b0;
    bus.L2_adder_rdy2 = 1'b0;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.Gl_tx_data_rdy === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic collect(input int nlines, input bit busy_mode,
                         output int first_cyc);
    bit ok;
    bit viol;
    logic [7:0] e;
    first_cyc = -1;
    for (int i = 0; i < nlines * NC; i++) begin
      wait_strobe(ok);
      checks++;
      if (!ok) begin
        $display("FAIL strobe_timeout: got no strobe, required char %0d", i);
        return;
      end
      if (i == 0) first_cyc = cyc;
      if (exp_q.size() == 0) begin
        $display("FAIL extra_strobe: got %h, required no strobe",
                 bus.Gl_tx_data);
        return;
      end
      e = exp_q.pop_front();
      if (bus.Gl_tx_data !== e)
        $display("FAIL char%0d: got %h, required %h", i, bus.Gl_tx_data, e);
      else passed++;
      if (busy_mode) begin
        bus.bu_tx_busy = 1'b1;
        viol = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (bus.Gl_tx_data_rdy !== 1'b0) viol = 1'b1;
          if (bus.Gl_tx_data !== e) viol = 1'b1;
        end
        bus.bu_tx_busy = 1'b0;
        checks++;
        if (viol)
          $display("FAIL busy_window%0d: got strobe/change %b, required 0",
                   i, viol);
        else passed++;
      end
    end
  endtask

  task automatic test_reset();
    bus.L2_adder_data1 = 8'h00;
    bus.L2_adder_data2 = 8'h00;
    bus.L2_adder_rdy1  = 1'b0;
    bus.L2_adder_rdy2  = 1'b0;
    bus.bu_tx_busy     = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Gl_tx_data !== 8'h00)
      $display("FAIL rst_data: got %h, required 00", bus.Gl_tx_data);
    else passed++;
    checks++;
    if (bus.Gl_tx_data_rdy !== 1'b0)
      $display("FAIL rst_rdy: got %b, required 0", bus.Gl_tx_data_rdy);
    else passed++;
    checks++;
    if (bus.pr_busy !== 1'b0)
      $display("FAIL rst_busy: got %b, required 0", bus.pr_busy);
    else passed++;
    checks++;
    if (bus.pr_drop !== 1'b0)
      $display("FAIL rst_drop: got %b, required 0", bus.pr_drop);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int rc, fc;
    pulse(1'b1, 1'b0, 8'h3A, 8'h00);
    rc = cyc;
    pulse(1'b0, 1'b1, 8'h00, 8'h0F);
    push_line(8'h3A, 8'h0F);
    collect(1, 1'b0, fc);
    checks++;
    if (fc - rc !== 3)
      $display("FAIL latency: got %0d, required 3", fc - rc);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.pr_busy !== 1'b0)
      $display("FAIL basic_idle: got %b, required 0", bus.pr_busy);
    else passed++;
  endtask

  task automatic test_busy();
    int fc;
    pulse(1'b1, 1'b1, 8'h5A, 8'hC3);
    push_line(8'h5A, 8'hC3);
    collect(1, 1'b1, fc);
  endtask

  task automatic test_back_to_back();
    int d0, fc;
    d0 = drop_cnt;
    pulse(1'b1, 1'b1, 8'h12, 8'h34);
    push_line(8'h12, 8'h34);
    fork
      collect(2, 1'b0, fc);
      begin
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0, 8'hAB, 8'h00);
        pulse(1'b0, 1'b1, 8'h00, 8'hCD);
        push_line(8'hAB, 8'hCD);
      end
    join
    @(negedge clk);
    checks++;
    if (drop_cnt - d0 !== 0)
      $display("FAIL buf_nodrop: got %0d, required 0", drop_cnt - d0);
    else passed++;
  endtask

  task automatic test_drop();
    int d0, fc;
    d0 = drop_cnt;
    pulse(1'b1, 1'b1, 8'h12, 8'h34);
    push_line(8'h12, 8'h34);
    fork
      collect(2, 1'b0, fc);
      begin
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0, 8'hAB, 8'h00);
        pulse(1'b0, 1'b1, 8'h00, 8'hCD);
        pulse(1'b1, 1'b0, 8'h77, 8'h00);
        push_line(8'h77, 8'hCD);
      end
    join
    @(negedge clk);
    checks++;
    if (drop_cnt - d0 !== 1)
      $display("FAIL drop_once: got %0d, required 1", drop_cnt - d0);
    else passed++;
  endtask

  task automatic test_simul();
    int d0, fc;
    d0 = drop_cnt;
    pulse(1'b1, 1'b1, 8'hFF, 8'h00);
    push_line(8'hFF, 8'h00);
    collect(1, 1'b0, fc);
    @(negedge clk);
    checks++;
    if (drop_cnt - d0 !== 0)
      $display("FAIL simul_nodrop: got %0d, required 0", drop_cnt - d0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s0, fc;
    logic [7:0] e;
    pulse(1'b1, 1'b1, 8'hDE, 8'hAD);
    push_line(8'hDE, 8'hAD);
    pulse(1'b1, 1'b0, 8'h99, 8'h00);
    for (int i = 0; i < 2; i++) begin
      wait_strobe(ok);
      checks++;
      e = exp_q.pop_front();
      if (!ok || bus.Gl_tx_data !== e)
        $display("FAIL mid_char%0d: got %h, required %h",
                 i, bus.Gl_tx_data, e);
      else passed++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    checks++;
    if ({bus.Gl_tx_data, bus.Gl_tx_data_rdy, bus.pr_busy, bus.pr_drop}
        !== 11'h000)
      $display("FAIL mid_rst_outs: got %h/%b/%b/%b, required 00/0/0/0",
               bus.Gl_tx_data, bus.Gl_tx_data_rdy, bus.pr_busy, bus.pr_drop);
    else passed++;
    s0 = strobe_cnt;
    pulse(1'b0, 1'b1, 8'h00, 8'h7E);
    repeat (10) @(negedge clk);
    checks++;
    if (strobe_cnt - s0 !== 0)
      $display("FAIL mid_discard: got %0d strobes, required 0",
               strobe_cnt - s0);
    else passed++;
    pulse(1'b1, 1'b0, 8'h4B, 8'h00);
    push_line(8'h4B, 8'h7E);
    collect(1, 1'b0, fc);
  endtask

  task automatic test_term();
    int fc;
    pulse(1'b1, 1'b1, 8'h00, 8'h01);
    push_line(8'h00, 8'h01);
    collect(1, 1'b0, fc);
    @(negedge clk);
    checks++;
    if (bus.pr_busy !== 1'b0)
      $display("FAIL term_idle: got %b, required 0", bus.pr_busy);
    else passed++;
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0)
      $display("FAIL leftover: got %0d chars, required 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_back_to_back();
    test_drop();
    test_simul();
    test_reset_mid();
    test_term();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
